// File: rtl/gray_to_binary_decoder_pkg.sv
// Shared constants and helpers for the Gray-to-binary decoder.
// Package name: gray_pkg.
//   DEFAULT_WIDTH : default decoder word width
//   gray2bin()    : prefix-XOR Gray decode over a zero-extended word
//   popcount()    : number of set bits, used by the step checker
package gray_pkg;

    localparam int unsigned DEFAULT_WIDTH = 4;
    // Helpers operate on a fixed wide word; callers zero-extend and truncate.
    localparam int unsigned MAX_WIDTH     = 64;
    localparam int unsigned CNT_WIDTH     = 7;

    // Zero bits above the caller's MSB leave the prefix XOR unchanged.
    function automatic logic [MAX_WIDTH-1:0] gray2bin(input logic [MAX_WIDTH-1:0] g);
        logic [MAX_WIDTH-1:0] b;
        b = '0;
        b[MAX_WIDTH-1] = g[MAX_WIDTH-1];
        for (int i = int'(MAX_WIDTH) - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    function automatic logic [CNT_WIDTH-1:0] popcount(input logic [MAX_WIDTH-1:0] v);
        logic [CNT_WIDTH-1:0] c;
        c = '0;
        for (int i = 0; i < int'(MAX_WIDTH); i++) begin
            c = c + CNT_WIDTH'(v[i]);
        end
        return c;
    endfunction

endpackage

// File: rtl/gray_to_binary_decoder_if.sv
// Handshake bundle between the Gray decoder and its neighbours.
//   in_valid/in_ready/in_gray       : Gray-coded input stream
//   out_valid/out_ready/out_binary  : decoded binary output stream
//   step_err/clr_err                : sticky step-violation flag and its clear
// slave  : decoder side
// master : producer/consumer side (driver of in_*, out_ready, clr_err)
interface gray_to_binary_decoder_if
    import gray_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_gray;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_binary;
    logic             step_err;
    logic             clr_err;

    modport slave (
        input  in_valid, in_gray, out_ready, clr_err,
        output in_ready, out_valid, out_binary, step_err
    );

    modport master (
        output in_valid, in_gray, out_ready, clr_err,
        input  in_ready, out_valid, out_binary, step_err
    );
endinterface

// File: rtl/gray_to_binary_decoder_step_checker.sv
// gray_step_checker: flags accepted Gray words that move more than one bit
// away from the previously accepted word.
//   clk, rst  : clock, async active-high reset
//   accept    : an input word is being accepted this cycle
//   gray      : the word being accepted
//   clr_err   : synchronous clear of step_err
//   step_err  : sticky violation flag (registered)
module gray_step_checker
    import gray_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             accept,
    input  logic [WIDTH-1:0] gray,
    input  logic             clr_err,
    output logic             step_err
);
    logic [WIDTH-1:0] last_g;
    logic             have_last;
    logic             violation_c;

    // The first word after reset has no predecessor and is never checked.
    assign violation_c = accept && have_last &&
                         (popcount(MAX_WIDTH'(gray ^ last_g)) >= CNT_WIDTH'(2));

    // History update; a new violation takes priority over a clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_g    <= '0;
            have_last <= 1'b0;
            step_err  <= 1'b0;
        end else begin
            if (accept) begin
                last_g    <= gray;
                have_last <= 1'b1;
            end
            if (violation_c) begin
                step_err <= 1'b1;
            end else if (clr_err) begin
                step_err <= 1'b0;
            end
        end
    end
endmodule

// File: rtl/gray_to_binary_decoder.sv
// gray_to_binary_decoder: two-stage pipelined Gray-to-binary decoder with
// valid/ready handshake and an optional step checker.
//   clk  : rising-edge clock
//   rst  : async active-high reset, discards in-flight words
//   bus  : gray_to_binary_decoder_if.slave (in_*, out_*, step_err, clr_err)
// Optional feature macro: GRAY_STEP_CHECK_EN builds the step checker;
// without it step_err is tied low and clr_err is ignored.
module gray_to_binary_decoder
    import gray_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic                     clk,
    input  logic                     rst,
    gray_to_binary_decoder_if.slave  bus
);
    logic             adv_c;
    logic             s1_valid;
    logic [WIDTH-1:0] s1_gray;
    logic             out_valid_q;
    logic [WIDTH-1:0] out_binary_q;

    // Whole pipeline moves together whenever the output slot can drain.
    assign adv_c        = !out_valid_q || bus.out_ready;
    assign bus.in_ready = adv_c;

    // S1 captures the raw Gray word; S2 holds the decoded result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid     <= 1'b0;
            s1_gray      <= '0;
            out_valid_q  <= 1'b0;
            out_binary_q <= '0;
        end else if (adv_c) begin
            s1_valid    <= bus.in_valid;
            out_valid_q <= s1_valid;
            if (bus.in_valid) begin
                s1_gray <= bus.in_gray;
            end
            if (s1_valid) begin
                out_binary_q <= WIDTH'(gray2bin(MAX_WIDTH'(s1_gray)));
            end
        end
    end

    assign bus.out_valid  = out_valid_q;
    assign bus.out_binary = out_binary_q;

`ifdef GRAY_STEP_CHECK_EN
    gray_step_checker #(
        .WIDTH (WIDTH)
    ) u_step_checker (
        .clk      (clk),
        .rst      (rst),
        .accept   (bus.in_valid && adv_c),
        .gray     (bus.in_gray),
        .clr_err  (bus.clr_err),
        .step_err (bus.step_err)
    );
`else
    logic unused_clr_err;
    assign unused_clr_err = bus.clr_err;
    assign bus.step_err   = 1'b0;
`endif
endmodule

// File: tb/tb_gray_to_binary_decoder.sv
// Directed self-checking bench for gray_to_binary_decoder (WIDTH = 4).
// Step-checker scenarios are selected by GRAY_STEP_CHECK_EN.
module tb_gray_to_binary_decoder;

    logic clk;
    logic rst;
    int   errors;
    int   checks;

    // Reflected Gray sequence; entry i decodes to binary i.
    logic [3:0] codes [16] = '{4'b0000, 4'b0001, 4'b0011, 4'b0010,
                               4'b0110, 4'b0111, 4'b0101, 4'b0100,
                               4'b1100, 4'b1101, 4'b1111, 4'b1110,
                               4'b1010, 4'b1011, 4'b1001, 4'b1000};

    gray_to_binary_decoder_if #(.WIDTH(4)) bus ();

    gray_to_binary_decoder #(.WIDTH(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pulse reset across one falling edge, leaving inputs idle.
    task automatic do_reset();
        @(negedge clk);
        rst          = 1'b1;
        bus.in_valid = 1'b0;
        bus.clr_err  = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_gray   = 4'b0000;
        bus.out_ready = 1'b1;
        bus.clr_err   = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", bus.out_valid); end
        checks++; if (bus.out_binary !== 4'b0000) begin errors++; $display("FAIL reset_out_binary: got %b expected 0000", bus.out_binary); end
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", bus.in_ready); end
        checks++; if (bus.step_err !== 1'b0) begin errors++; $display("FAIL reset_step_err: got %b expected 0", bus.step_err); end
        rst = 1'b0;
        @(negedge clk);
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL post_reset_in_ready: got %b expected 1", bus.in_ready); end
    endtask

    task automatic test_latency();
        do_reset();
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_gray   = 4'b0110;
        @(negedge clk);
        bus.in_valid = 1'b0;
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL latency_early: got out_valid %b expected 0", bus.out_valid); end
        @(negedge clk);
        checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL latency_valid: got out_valid %b expected 1", bus.out_valid); end
        checks++; if (bus.out_binary !== 4'b0100) begin errors++; $display("FAIL latency_data: got %b expected 0100", bus.out_binary); end
        @(negedge clk);
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL latency_bubble: got out_valid %b expected 0", bus.out_valid); end
    endtask

    task automatic test_stream();
        int sent  = 0;
        int got   = 0;
        int first = -1;
        int last  = -1;
        int cyc   = 0;
        do_reset();
        bus.out_ready = 1'b1;
        while (got < 16 && cyc < 64) begin
            if (sent < 16) begin
                bus.in_valid = 1'b1;
                bus.in_gray  = codes[sent];
            end else begin
                bus.in_valid = 1'b0;
            end
            #1;
            if (bus.out_valid && bus.out_ready) begin
                checks++;
                if (bus.out_binary !== 4'(got)) begin errors++; $display("FAIL stream_data[%0d]: got %b expected %b", got, bus.out_binary, 4'(got)); end
                if (first < 0) first = cyc;
                last = cyc;
                got++;
            end
            if (bus.in_valid && bus.in_ready) sent++;
            @(negedge clk);
            cyc++;
        end
        bus.in_valid = 1'b0;
        checks++; if (got != 16) begin errors++; $display("FAIL stream_count: got %0d words expected 16", got); end
        checks++; if (last - first != 15) begin errors++; $display("FAIL stream_no_bubble: got span %0d expected 15", last - first); end
    endtask

    task automatic test_backpressure();
        int         sent  = 0;
        int         got   = 0;
        int         cyc   = 0;
        int         stall = 0;
        bit         stalled_prev = 1'b0;
        logic [3:0] held  = 4'b0000;
        do_reset();
        while (got < 16 && cyc < 80) begin
            bus.out_ready = !(cyc >= 6 && cyc < 9);
            if (sent < 16) begin
                bus.in_valid = 1'b1;
                bus.in_gray  = codes[sent];
            end else begin
                bus.in_valid = 1'b0;
            end
            #1;
            if (bus.out_valid && !bus.out_ready) begin
                stall++;
                checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready: got %b expected 0 at cycle %0d", bus.in_ready, cyc); end
                if (stalled_prev) begin
                    checks++; if (bus.out_binary !== held) begin errors++; $display("FAIL bp_hold: got %b expected %b at cycle %0d", bus.out_binary, held, cyc); end
                end
                held         = bus.out_binary;
                stalled_prev = 1'b1;
            end else begin
                stalled_prev = 1'b0;
            end
            if (bus.out_valid && bus.out_ready) begin
                checks++;
                if (bus.out_binary !== 4'(got)) begin errors++; $display("FAIL bp_data[%0d]: got %b expected %b", got, bus.out_binary, 4'(got)); end
                got++;
            end
            if (bus.in_valid && bus.in_ready) sent++;
            @(negedge clk);
            cyc++;
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        checks++; if (got != 16) begin errors++; $display("FAIL bp_count: got %0d words expected 16", got); end
        checks++; if (stall != 3) begin errors++; $display("FAIL bp_stall_cycles: got %0d expected 3", stall); end
        @(negedge clk);
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL bp_no_dup: got out_valid %b expected 0", bus.out_valid); end
    endtask

`ifdef GRAY_STEP_CHECK_EN
    task automatic test_step_check();
        do_reset();
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_gray   = 4'b0000;
        @(negedge clk);
        checks++; if (bus.step_err !== 1'b0) begin errors++; $display("FAIL step_first: got %b expected 0", bus.step_err); end
        bus.in_gray = 4'b0011;
        @(negedge clk);
        bus.in_valid = 1'b0;
        checks++; if (bus.step_err !== 1'b1) begin errors++; $display("FAIL step_violation: got %b expected 1", bus.step_err); end
        bus.clr_err = 1'b1;
        @(negedge clk);
        bus.clr_err = 1'b0;
        checks++; if (bus.step_err !== 1'b0) begin errors++; $display("FAIL step_clear: got %b expected 0", bus.step_err); end
        bus.in_valid = 1'b1;
        bus.in_gray  = 4'b0010;
        @(negedge clk);
        checks++; if (bus.step_err !== 1'b0) begin errors++; $display("FAIL step_legal_0010: got %b expected 0", bus.step_err); end
        bus.in_gray = 4'b0110;
        @(negedge clk);
        checks++; if (bus.step_err !== 1'b0) begin errors++; $display("FAIL step_legal_0110: got %b expected 0", bus.step_err); end
        bus.in_gray = 4'b0110;
        @(negedge clk);
        checks++; if (bus.step_err !== 1'b0) begin errors++; $display("FAIL step_repeat: got %b expected 0", bus.step_err); end
        // 0110 -> 0000 is distance 2 while clr_err is also high.
        bus.in_gray = 4'b0000;
        bus.clr_err = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.clr_err  = 1'b0;
        checks++; if (bus.step_err !== 1'b1) begin errors++; $display("FAIL step_violation_beats_clr: got %b expected 1", bus.step_err); end
    endtask

    task automatic test_wrap();
        do_reset();
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_gray   = 4'b1000;
        @(negedge clk);
        checks++; if (bus.step_err !== 1'b0) begin errors++; $display("FAIL wrap_first: got %b expected 0", bus.step_err); end
        bus.in_gray = 4'b0000;
        @(negedge clk);
        bus.in_valid = 1'b0;
        checks++; if (bus.step_err !== 1'b0) begin errors++; $display("FAIL wrap_step: got %b expected 0", bus.step_err); end
    endtask
`else
    task automatic test_step_disabled();
        do_reset();
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_gray   = 4'b0000;
        @(negedge clk);
        bus.in_gray = 4'b0011;
        @(negedge clk);
        bus.in_valid = 1'b0;
        checks++; if (bus.step_err !== 1'b0) begin errors++; $display("FAIL step_disabled: got %b expected 0", bus.step_err); end
        bus.clr_err = 1'b1;
        @(negedge clk);
        bus.clr_err = 1'b0;
        checks++; if (bus.step_err !== 1'b0) begin errors++; $display("FAIL step_disabled_clr: got %b expected 0", bus.step_err); end
    endtask
`endif

    task automatic test_midreset();
        do_reset();
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_gray   = 4'b0101;
        @(negedge clk);
        bus.in_gray = 4'b0110;
        @(negedge clk);
        bus.in_valid = 1'b0;
        checks++; if (bus.out_binary !== 4'b0110 || bus.out_valid !== 1'b1) begin errors++; $display("FAIL midreset_inflight: got %b/%b expected 1/0110", bus.out_valid, bus.out_binary); end
        rst = 1'b1;
        #1;
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL midreset_out_valid: got %b expected 0", bus.out_valid); end
        checks++; if (bus.step_err !== 1'b0) begin errors++; $display("FAIL midreset_step_err: got %b expected 0", bus.step_err); end
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL midreset_stale[%0d]: got out_valid %b expected 0", i, bus.out_valid); end
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        test_reset();
        test_latency();
        test_stream();
        test_backpressure();
`ifdef GRAY_STEP_CHECK_EN
        test_step_check();
        test_wrap();
`else
        test_step_disabled();
`endif
        test_midreset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
